wptr_full: RTL and testbench

Write-domain pointer and full-flag generator for the asynchronous FIFO. It is the sending end of the pointer-crossing path. It holds the binary write counter and drives the memory write address. It publishes a registered Gray-coded write pointer for the read-domain dual-flop synchronizer, and compares the synchronized read pointer against its own pointer to produce full, fill-level, almost-full and overflow status.

---
 rtl/wptr_full_pkg.sv | 14 +
 rtl/wptr_full_gray2bin.sv | 11 +
 rtl/wptr_full.sv | 47 ++++
 tb/tb_wptr_full.sv | 137 +++++++++++++
 4 files changed

// File: rtl/wptr_full_pkg.sv
// wptr_full_pkg: shared FIFO pointer helpers (Gray conversions, pointer-width convention)
package wptr_full_pkg;
   // Pointers carry one extra wrap bit above the address bits.
   localparam int PTR_EXTRA = 1;
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
endpackage

// File: rtl/wptr_full_gray2bin.sv
// wptr_full_gray2bin: parameterized Gray-to-binary converter
module wptr_full_gray2bin #(
   parameter int W = 5
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin[i] = ^gray[W-1:i];
   end
endmodule

// File: rtl/wptr_full.sv
// wptr_full: write pointer, Gray pointer publication and full/level/overflow status
module wptr_full
   import wptr_full_pkg::*;
#(
   parameter int ADDRSIZE    = 4,
   parameter int AFULL_LEVEL = 2**ADDRSIZE - 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  winc,
   input  logic [ADDRSIZE:0]     wq2_rptr,
   output logic [ADDRSIZE-1:0]   waddr,
   output logic                  wen,
   output logic [ADDRSIZE:0]     wptr,
   output logic                  wfull,
   output logic                  walmost_full,
   output logic [ADDRSIZE:0]     wcount,
   output logic                  wovf
);
   localparam int PW = ADDRSIZE + PTR_EXTRA;
   localparam logic [PW-1:0] AF = PW'(AFULL_LEVEL);
   logic [PW-1:0] wbin, wbin_next, wgray_next, rbin_s, wcount_next;
   wptr_full_gray2bin #(.W(PW)) u_g2b (.gray(wq2_rptr), .bin(rbin_s));
   // Reset also masks the memory write so nothing lands during reset.
   assign wen         = winc & ~wfull & ~rst;
   assign wbin_next   = wbin + PW'(wen);
   assign wgray_next  = PW'(bin2gray(32'(wbin_next)));
   assign wcount_next = wbin_next - rbin_s;
   assign waddr       = wbin[ADDRSIZE-1:0];
   always_ff @(posedge clk) begin
      if (rst) begin
         wbin         <= '0;
         wptr         <= '0;
         wfull        <= 1'b0;
         wcount       <= '0;
         walmost_full <= 1'b0;
         wovf         <= 1'b0;
      end else begin
         wbin         <= wbin_next;
         wptr         <= wgray_next;
         wfull        <= wgray_next == {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
         wcount       <= wcount_next;
         walmost_full <= wcount_next >= AF;
         wovf         <= wovf | (winc & wfull);
      end
   end
endmodule

// File: tb/tb_wptr_full.sv
// tb_wptr_full: directed vectors plus wrap and random scoreboard checks for wptr_full
module tb_wptr_full;
   typedef struct {
      logic       rst, winc;
      logic [2:0] rq;
      logic       wen;
      logic [1:0] waddr;
      logic [2:0] wptr;
      logic       wfull;
      logic [2:0] wcount;
      logic       waf, wovf;
   } vec_t;
   logic clk = 1'b0;
   logic rst, winc, wen, wfull, walmost_full, wovf;
   logic [2:0] wq2_rptr, wptr, wcount;
   logic [1:0] waddr;
   logic [1:0] mode;
   logic [2:0] rq_drv, q1, q2, r1, r2, rbin;
   logic rd_en;
   int mem [4];
   int wseq = 0;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   wptr_full #(.ADDRSIZE(2), .AFULL_LEVEL(3)) dut (
      .clk(clk), .rst(rst), .winc(winc), .wq2_rptr(wq2_rptr), .waddr(waddr), .wen(wen),
      .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full), .wcount(wcount), .wovf(wovf)
   );
   function automatic logic [2:0] b2g(input logic [2:0] b);
      return {b[2], b[2] ^ b[1], b[1] ^ b[0]};
   endfunction
   function automatic logic [2:0] g2b(input logic [2:0] g);
      return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
   endfunction
   assign wq2_rptr = mode == 2'd0 ? rq_drv : mode == 2'd1 ? q2 : r2;
   // Read-side model: sees wptr through two flops and returns its Gray pointer through two flops.
   always @(posedge clk) begin
      if (rst) begin
         q1 <= '0; q2 <= '0; r1 <= '0; r2 <= '0; rbin <= '0;
      end else begin
         q1 <= wptr; q2 <= q1;
         r1 <= b2g(rbin); r2 <= r1;
         if (rd_en) rbin <= rbin + 3'd1;
      end
      if (wen) begin
         mem[waddr] <= wseq;
         wseq <= wseq + 1;
      end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask
   initial begin
      vec_t v [11];
      logic [2:0] wrap_exp [8];
      logic [2:0] mbin, nb, nc, prev;
      logic mfull, ew;
      int rseq;
      rst = 1'b1; winc = 1'b0; rq_drv = '0; mode = 2'd0; rd_en = 1'b0;
      v[0]  = '{1'b1, 1'b1, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0};
      v[1]  = '{1'b1, 1'b1, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0};
      v[2]  = '{1'b0, 1'b1, 3'b000, 1'b1, 2'd1, 3'b001, 1'b0, 3'd1, 1'b0, 1'b0};
      v[3]  = '{1'b0, 1'b1, 3'b000, 1'b1, 2'd2, 3'b011, 1'b0, 3'd2, 1'b0, 1'b0};
      v[4]  = '{1'b0, 1'b1, 3'b000, 1'b1, 2'd3, 3'b010, 1'b0, 3'd3, 1'b1, 1'b0};
      v[5]  = '{1'b0, 1'b1, 3'b000, 1'b1, 2'd0, 3'b110, 1'b1, 3'd4, 1'b1, 1'b0};
      v[6]  = '{1'b0, 1'b1, 3'b000, 1'b0, 2'd0, 3'b110, 1'b1, 3'd4, 1'b1, 1'b1};
      v[7]  = '{1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 3'b110, 1'b1, 3'd4, 1'b1, 1'b1};
      v[8]  = '{1'b0, 1'b0, 3'b001, 1'b0, 2'd0, 3'b110, 1'b0, 3'd3, 1'b1, 1'b1};
      v[9]  = '{1'b0, 1'b1, 3'b001, 1'b1, 2'd1, 3'b111, 1'b1, 3'd4, 1'b1, 1'b1};
      v[10] = '{1'b1, 1'b0, 3'b001, 1'b0, 2'd0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0};
      wrap_exp = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         rst = v[i].rst; winc = v[i].winc; rq_drv = v[i].rq;
         #1 chk($sformatf("v%0d_wen", i), 32'(wen), 32'(v[i].wen));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_waddr", i), 32'(waddr), 32'(v[i].waddr));
         chk($sformatf("v%0d_wptr", i), 32'(wptr), 32'(v[i].wptr));
         chk($sformatf("v%0d_wfull", i), 32'(wfull), 32'(v[i].wfull));
         chk($sformatf("v%0d_wcount", i), 32'(wcount), 32'(v[i].wcount));
         chk($sformatf("v%0d_walmost_full", i), 32'(walmost_full), 32'(v[i].waf));
         chk($sformatf("v%0d_wovf", i), 32'(wovf), 32'(v[i].wovf));
      end
      // Wrap: eight writes with the read pointer trailing wptr by two cycles.
      @(negedge clk);
      rst = 1'b0; mode = 2'd1;
      for (int k = 0; k < 8; k++) begin
         winc = 1'b1;
         #1 chk($sformatf("wrap%0d_waddr_pre", k), 32'(waddr), 32'(k % 4));
         @(posedge clk);
         #1;
         chk($sformatf("wrap%0d_wptr", k), 32'(wptr), 32'(wrap_exp[k]));
         chk($sformatf("wrap%0d_wfull", k), 32'(wfull), 32'd0);
         @(negedge clk);
      end
      chk("wrap_waddr_end", 32'(waddr), 32'd0);
      // Random traffic against a reader model and a data scoreboard.
      rst = 1'b1; winc = 1'b0; mode = 2'd2;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mbin = '0; mfull = 1'b0; prev = '0; rseq = wseq;
      for (int c = 0; c < 200; c++) begin
         winc = $urandom_range(0, 3) != 0;
         rd_en = ($urandom_range(0, 2) == 0) && (rbin != g2b(q2));
         #1;
         ew = winc & ~mfull;
         chk("rnd_wen", 32'(wen), 32'(ew));
         if (rd_en) begin
            chk("rnd_rd_data", 32'(mem[rbin[1:0]]), 32'(rseq));
            rseq++;
         end
         nb = mbin + {2'b00, ew};
         nc = nb - g2b(wq2_rptr);
         @(posedge clk);
         #1;
         chk("rnd_wptr", 32'(wptr), 32'(b2g(nb)));
         chk("rnd_hamming", 32'($countones(wptr ^ prev) <= 1), 32'd1);
         chk("rnd_wfull", 32'(wfull), 32'(nc == 3'd4));
         chk("rnd_wcount", 32'(wcount), 32'(nc));
         chk("rnd_wcount_max", 32'(wcount <= 3'd4), 32'd1);
         chk("rnd_walmost_full", 32'(walmost_full), 32'(nc >= 3'd3));
         chk("rnd_waddr", 32'(waddr), 32'(nb[1:0]));
         mbin = nb; mfull = nc == 3'd4; prev = wptr;
         @(negedge clk);
         rd_en = 1'b0;
      end
      chk("rnd_write_count", 32'(wseq - rseq <= 4), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
